// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_pkg                                                |
// | Description : Shared types, constants and the arbitration rule used by     |
// |               the SDRAM two-port arbiter and its tag FIFO.                 |
// | Contents    : arb_state_t  grant state (IDLE / GNT0 / GNT1)                |
// |               PORT_VGA / PORT_DRAW  1-bit port IDs stored in the tag FIFO  |
// |               DEF_*         default parameter values                       |
// |               arbitrate()   fixed-priority rule with starvation override   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic PORT_VGA  = 1'b0;
    localparam logic PORT_DRAW = 1'b1;

    localparam int DEF_ADDR_W       = 25;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_MAX_PEND     = 8;
    localparam int DEF_STARVE_LIMIT = 16;
    localparam int BE_W             = 2;

    // Port 0 wins unless port 1 is waiting and has already been passed over
    // STARVE_LIMIT times (starve_ok is low in that case).
    function automatic arb_state_t arbitrate(
        input logic req0,
        input logic req1,
        input logic starve_ok
    );
        if (req0 && (!req1 || starve_ok)) begin
            return GNT0;
        end else if (req1) begin
            return GNT1;
        end else begin
            return IDLE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_tag_fifo                                                 |
// | Description : 1-bit wide synchronous FIFO holding the port ID of every     |
// |               accepted read, in issue order.                               |
// | Ports       : clk, rst       clock, synchronous active-high reset          |
// |               i_push/i_data  write one ID (honoured when not full, or when |
// |                              a pop happens in the same cycle)              |
// |               i_pop          discard head (ignored when empty)             |
// |               o_head         ID at the head of the queue                   |
// |               o_full/o_empty occupancy flags                               |
// |               o_count        number of stored IDs (0..DEPTH)               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module arb_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_data,
    input  logic                   i_pop,
    output logic                   o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_port_arbiter                                           |
// | Description : Two-requester Avalon-MM arbiter in front of the SDRAM        |
// |               controller. Port 0 (VGA scan-out, read-only) has fixed       |
// |               priority; port 1 (draw/fill, read/write) is protected by a   |
// |               starvation counter. Read data is steered back to the issuer  |
// |               through an in-order tag FIFO.                                |
// | Ports       : clk, reset              clock, synchronous active-high reset |
// |               m0_*                    port-0 Avalon slave side (reads)     |
// |               m1_*                    port-1 Avalon slave side (rd/wr)     |
// |               s_*                     Avalon master to SDRAM controller    |
// |               pend_count              reads accepted, data not yet back    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_PEND     = DEF_MAX_PEND,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      reset,
    // port 0: VGA reader
    input  logic [ADDR_W-1:0]         m0_address,
    input  logic                      m0_read,
    output logic                      m0_waitrequest,
    output logic [DATA_W-1:0]         m0_readdata,
    output logic                      m0_readdatavalid,
    // port 1: draw/fill engine
    input  logic [ADDR_W-1:0]         m1_address,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [DATA_W-1:0]         m1_writedata,
    input  logic [BE_W-1:0]           m1_byteenable,
    output logic                      m1_waitrequest,
    output logic [DATA_W-1:0]         m1_readdata,
    output logic                      m1_readdatavalid,
    // SDRAM controller
    output logic [ADDR_W-1:0]         s_address,
    output logic                      s_read,
    output logic                      s_write,
    output logic [DATA_W-1:0]         s_writedata,
    output logic [BE_W-1:0]           s_byteenable,
    input  logic                      s_waitrequest,
    input  logic [DATA_W-1:0]         s_readdata,
    input  logic                      s_readdatavalid,
    // debug
    output logic [$clog2(MAX_PEND):0] pend_count
);

    localparam int                   CNT_W        = $clog2(MAX_PEND) + 1;
    localparam int                   STARVE_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]  C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          r_state;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0]    r_orphans;

    logic                w_req0;
    logic                w_req1;
    logic                w_gnt_read;
    logic                w_gnt_write;
    logic                w_read_blocked;
    logic                w_accept;
    logic                w_accept0;
    logic                w_accept1;
    logic                w_push;
    logic                w_push_id;
    logic                w_pop;
    logic                w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [STARVE_W-1:0] w_starve_nxt;
    arb_state_t          w_rearb;

    assign w_req0 = m0_read;
    assign w_req1 = m1_read | m1_write;

    // Command presented by the granted port. Read+write together on port 1
    // is illegal and is treated as a write.
    always_comb begin
        w_gnt_read  = 1'b0;
        w_gnt_write = 1'b0;
        case (r_state)
            GNT0: w_gnt_read = m0_read;
            GNT1: begin
                w_gnt_write = m1_write;
                w_gnt_read  = m1_read & ~m1_write;
            end
            default: ;
        endcase
    end

    assign w_read_blocked = w_gnt_read & w_fifo_full;
    assign w_accept  = (w_gnt_write | (w_gnt_read & ~w_read_blocked)) & ~s_waitrequest & ~reset;
    assign w_accept0 = w_accept & (r_state == GNT0);
    assign w_accept1 = w_accept & (r_state == GNT1);

    // Counter value after this cycle; re-arbitration looks at it so the port-1
    // turn comes right after the STARVE_LIMIT-th consecutive port-0 accept.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_accept1 || !w_req1) begin
            w_starve_nxt = '0;
        end else if (w_accept0 && (r_starve_cnt != C_STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    assign w_rearb = arbitrate(w_req0, w_req1, w_starve_nxt < C_STARVE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            case (r_state)
                IDLE: r_state <= w_rearb;
                GNT0, GNT1: begin
                    if (w_accept || !(w_gnt_read || w_gnt_write)) begin
                        // Accepted, or the granted port has nothing to present:
                        // hand the path to whoever wins now.
                        r_state <= w_rearb;
                    end else if ((r_state == GNT0) && w_read_blocked && m1_write) begin
                        // A read stalled on a full tag FIFO never reaches s_*,
                        // so moving the grant does not break command hold on
                        // the controller side; it lets port-1 writes through.
                        r_state <= GNT1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath to the controller follows the registered grant.
    assign s_address    = (r_state == GNT1) ? m1_address : m0_address;
    assign s_writedata  = m1_writedata;
    assign s_byteenable = (r_state == GNT1) ? m1_byteenable : {BE_W{1'b1}};
    assign s_read       = w_gnt_read & ~w_read_blocked & ~reset;
    assign s_write      = w_gnt_write & ~reset;

    assign m0_waitrequest = (r_state != GNT0) | s_waitrequest | w_read_blocked | reset;
    assign m1_waitrequest = (r_state != GNT1) | s_waitrequest | w_read_blocked | reset;

    // Response routing: the head tag names the issuer of the oldest read.
    assign w_push    = w_accept & w_gnt_read;
    assign w_push_id = (r_state == GNT1) ? PORT_DRAW : PORT_VGA;
    assign w_pop     = s_readdatavalid & ~w_fifo_empty & ~reset;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & (w_fifo_head == PORT_VGA);
    assign m1_readdatavalid = w_pop & (w_fifo_head == PORT_DRAW);
    assign pend_count       = w_fifo_count;

    arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_id),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Reads still in flight when reset hits come back with an empty FIFO.
    // They are dropped like any unmatched response, but are remembered here
    // so that only genuinely unexpected responses trip the check below.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_orphans <= w_fifo_count;
        end else if (s_readdatavalid && w_fifo_empty && (r_orphans != '0)) begin
            r_orphans <= r_orphans - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_rdv_without_tag : assert (!(s_readdatavalid && w_fifo_empty) || (r_orphans != '0));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_port_arbiter                                        |
// | Description : Directed self-checking bench for sdram_port_arbiter          |
// |               (STARVE_LIMIT = 4, MAX_PEND = 8). The SDRAM controller side  |
// |               is driven step by step; expected values are hand-computed.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [1:0]        m1_byteenable;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [1:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [3:0]        pend_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_PEND     (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .pend_count       (pend_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are changed
    // there and outputs sampled one unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        m0_address      = '0;
        m0_read         = 1'b0;
        m1_address      = '0;
        m1_read         = 1'b0;
        m1_write        = 1'b0;
        m1_writedata    = '0;
        m1_byteenable   = 2'b00;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- reset then idle ----------------------------------------------
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            chk("idle_s_read",  32'(s_read), 0);
            chk("idle_s_write", 32'(s_write), 0);
            chk("idle_m0_wait", 32'(m0_waitrequest), 1);
            chk("idle_m1_wait", 32'(m1_waitrequest), 1);
            chk("idle_pend",    32'(pend_count), 0);
        end

        // ---- contention: 4 port-0 accepts, then the port-1 write ----------
        cyc();
        m0_read = 1'b1; m0_address = 25'h100;
        m1_write = 1'b1; m1_address = 25'h2000; m1_writedata = 16'hABCD; m1_byteenable = 2'b11;
        #1;
        chk("cont_idle_m0_wait", 32'(m0_waitrequest), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_address = 25'h100 + 25'(i);
            #1;
            chk("cont_p0_read",  32'(s_read), 1);
            chk("cont_p0_addr",  32'(s_address), 32'h100 + 32'(i));
            chk("cont_p0_wait",  32'(m0_waitrequest), 0);
            chk("cont_p1_held",  32'(m1_waitrequest), 1);
        end
        cyc(); #1;
        chk("cont_p1_write", 32'(s_write), 1);
        chk("cont_p1_noread", 32'(s_read), 0);
        chk("cont_p1_addr",  32'(s_address), 32'h2000);
        chk("cont_p1_data",  32'(s_writedata), 32'hABCD);
        chk("cont_p1_wait",  32'(m1_waitrequest), 0);
        chk("cont_p0_held",  32'(m0_waitrequest), 1);
        cyc();
        m1_write = 1'b0; m0_address = 25'h104;
        #1;
        chk("cont_resume_read", 32'(s_read), 1);
        chk("cont_resume_addr", 32'(s_address), 32'h104);
        cyc();
        m0_address = 25'h105;
        #1;
        chk("cont_resume_addr2", 32'(s_address), 32'h105);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("cont_no_cmd", 32'(s_read), 0);
        chk("cont_pend6",  32'(pend_count), 6);
        for (int k = 0; k < 6; k++) begin
            cyc();
            s_readdatavalid = 1'b1; s_readdata = 16'h5000 + 16'(k);
            #1;
            chk("cont_rsp_m0_valid", 32'(m0_readdatavalid), 1);
            chk("cont_rsp_m0_data",  32'(m0_readdata), 32'h5000 + 32'(k));
            chk("cont_rsp_m1_quiet", 32'(m1_readdatavalid), 0);
        end
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("cont_drained", 32'(pend_count), 0);

        // ---- interleaved reads: responses routed to their issuers ----------
        cyc();
        m0_read = 1'b1; m0_address = 25'h10;
        m1_read = 1'b1; m1_address = 25'h20;
        #1;
        chk("il_idle_m0_wait", 32'(m0_waitrequest), 1);
        cyc(); #1;
        chk("il_m0_read", 32'(s_read), 1);
        chk("il_m0_addr", 32'(s_address), 32'h10);
        chk("il_m1_held", 32'(m1_waitrequest), 1);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("il_gap_no_read", 32'(s_read), 0);
        cyc(); #1;
        chk("il_m1_read", 32'(s_read), 1);
        chk("il_m1_addr", 32'(s_address), 32'h20);
        chk("il_m1_wait", 32'(m1_waitrequest), 0);
        cyc();
        m1_read = 1'b0;
        #1;
        chk("il_pend2", 32'(pend_count), 2);
        cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        #1;
        chk("il_rsp0_m0_valid", 32'(m0_readdatavalid), 1);
        chk("il_rsp0_m0_data",  32'(m0_readdata), 32'h1111);
        chk("il_rsp0_m1_quiet", 32'(m1_readdatavalid), 0);
        cyc();
        s_readdata = 16'h2222;
        #1;
        chk("il_rsp1_m1_valid", 32'(m1_readdatavalid), 1);
        chk("il_rsp1_m1_data",  32'(m1_readdata), 32'h2222);
        chk("il_rsp1_m0_quiet", 32'(m0_readdatavalid), 0);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("il_drained", 32'(pend_count), 0);

        // ---- full tag FIFO: 9th read stalls, port-1 write still passes -----
        cyc();
        m0_read = 1'b1; m0_address = 25'h300;
        #1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            m0_address = 25'h300 + 25'(i);
            #1;
            chk("full_fill_read", 32'(s_read), 1);
            chk("full_fill_addr", 32'(s_address), 32'h300 + 32'(i));
        end
        cyc();
        m0_address = 25'h308;
        m1_write = 1'b1; m1_address = 25'h400; m1_writedata = 16'h55AA; m1_byteenable = 2'b01;
        #1;
        chk("full_pend8",      32'(pend_count), 8);
        chk("full_read_gated", 32'(s_read), 0);
        chk("full_m0_stalled", 32'(m0_waitrequest), 1);
        cyc(); #1;
        chk("full_wr_write", 32'(s_write), 1);
        chk("full_wr_addr",  32'(s_address), 32'h400);
        chk("full_wr_data",  32'(s_writedata), 32'h55AA);
        chk("full_wr_be",    32'(s_byteenable), 32'h1);
        chk("full_wr_wait",  32'(m1_waitrequest), 0);
        cyc();
        m1_write = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'h7777;
        #1;
        chk("full_pop_still_gated", 32'(s_read), 0);
        chk("full_pop_m0_valid",    32'(m0_readdatavalid), 1);
        chk("full_pop_m0_data",     32'(m0_readdata), 32'h7777);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("full_unblock_pend7", 32'(pend_count), 7);
        chk("full_unblock_read",  32'(s_read), 1);
        chk("full_unblock_addr",  32'(s_address), 32'h308);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("full_back_to_8", 32'(pend_count), 8);
        for (int k = 0; k < 8; k++) begin
            cyc();
            s_readdatavalid = 1'b1; s_readdata = 16'h0A00 + 16'(k);
            #1;
            chk("full_drain_m0_valid", 32'(m0_readdatavalid), 1);
        end
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk("full_drained", 32'(pend_count), 0);

        // ---- hold rule: grant stays on a stalled port-1 write --------------
        cyc();
        m1_write = 1'b1; m1_address = 25'h500; m1_writedata = 16'h1234; m1_byteenable = 2'b11;
        s_waitrequest = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            m0_read = 1'b1; m0_address = 25'h600;
            #1;
            chk("hold_write", 32'(s_write), 1);
            chk("hold_addr",  32'(s_address), 32'h500);
            chk("hold_data",  32'(s_writedata), 32'h1234);
            chk("hold_m0_wait", 32'(m0_waitrequest), 1);
            chk("hold_m1_wait", 32'(m1_waitrequest), 1);
        end
        cyc();
        s_waitrequest = 1'b0;
        #1;
        chk("hold_accept_write", 32'(s_write), 1);
        chk("hold_accept_addr",  32'(s_address), 32'h500);
        chk("hold_accept_m1",    32'(m1_waitrequest), 0);
        cyc();
        m1_write = 1'b0;
        #1;
        chk("hold_then_gnt0_read", 32'(s_read), 1);
        chk("hold_then_gnt0_addr", 32'(s_address), 32'h600);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("hold_pend1", 32'(pend_count), 1);

        // ---- reset with 3 reads in flight ----------------------------------
        cyc();
        m0_read = 1'b1; m0_address = 25'h700;
        #1;
        cyc(); #1;
        chk("rst_rd_a", 32'(s_address), 32'h700);
        cyc();
        m0_address = 25'h701;
        #1;
        chk("rst_rd_b", 32'(s_read), 1);
        cyc();
        m0_read = 1'b0;
        #1;
        chk("rst_pend3", 32'(pend_count), 3);
        cyc();
        reset = 1'b1;
        #1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_pend0",   32'(pend_count), 0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_s_read",  32'(s_read), 0);
        chk("rst_s_write", 32'(s_write), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
            #1;
            chk("rst_late_m0_quiet", 32'(m0_readdatavalid), 0);
            chk("rst_late_m1_quiet", 32'(m1_readdatavalid), 0);
            chk("rst_late_pend",     32'(pend_count), 0);
        end
        cyc();
        s_readdatavalid = 1'b0;
        m0_read = 1'b1; m0_address = 25'h800;
        #1;
        chk("post_rst_idle", 32'(m0_waitrequest), 1);
        cyc(); #1;
        chk("post_rst_read", 32'(s_read), 1);
        chk("post_rst_addr", 32'(s_address), 32'h800);
        cyc();
        m0_read = 1'b0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
